// File: rtl/sort_pkg.sv
// sort_pkg: shared types and default geometry for the sort engine client.
// Holds the initiator state enum and the word-width/depth defaults.
package sort_pkg;

  localparam int SORT_DATA_W = 8;
  localparam int SORT_DEPTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    RADDR,
    RDATA,
    OUT
  } sort_init_state_t;

endpackage

// File: rtl/sort_order_checker.sv
// sort_order_checker: sticky non-decreasing order check on read-back words.
// Ports: clk, rst, clr (restart job), cap (word valid), data, err (sticky).
module sort_order_checker #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap,
  input  logic [DATA_W-1:0] data,
  output logic              err
);

  logic [DATA_W-1:0] prev;
  logic              first;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev  <= '0;
      first <= 1'b1;
      err   <= 1'b0;
    end else if (cap) begin
      // first word of a job has nothing to compare against
      if (!first && (data < prev))
        err <= 1'b1;
      prev  <= data;
      first <= 1'b0;
    end
  end

endmodule

// File: rtl/sort_initiator.sv
// sort_initiator: loads DEPTH words into the sorter memory, starts the sort,
// waits for done, then streams the sorted memory out in address order.
// Ports: clk/rst, in_* (input stream), mem_* (sorter memory port),
// start_sort/done (sorter handshake), out_* (output stream), busy, order_err.
// Build option: define SORT_CHECK_EN to compile in the order checker;
// without it order_err is tied low.
module sort_initiator
  import sort_pkg::*;
#(
  parameter int DATA_W = SORT_DATA_W,
  parameter int DEPTH  = SORT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              start_sort,
  input  logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              order_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  sort_init_state_t  state;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic              loading;
  logic              reading;
  logic              accept;

  assign loading   = (state == IDLE) || (state == LOAD);
  assign reading   = (state == RADDR) || (state == RDATA);
  assign in_ready  = loading && !rst;
  assign accept    = in_valid && in_ready;
  assign mem_we    = accept;
  assign mem_wdata = accept ? in_data : '0;
  // read address is held through RDATA so the data returned matches rd_cnt
  assign mem_addr  = rst ? '0 : (reading ? rd_cnt : wr_cnt);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      start_sort <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      start_sort <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          if (accept) begin
            // wraps to 0 after the last word, ready for the next job
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST) begin
              state      <= START;
              start_sort <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (done) begin
            rd_cnt <= '0;
            state  <= RADDR;
          end
        end
        RADDR: state <= RDATA;
        RDATA: begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
          out_last  <= (rd_cnt == LAST);
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (rd_cnt == LAST) begin
              rd_cnt <= '0;
              state  <= IDLE;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
              state  <= RADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SORT_CHECK_EN
  logic chk_clr;
  logic chk_cap;

  assign chk_clr = (state == WAIT) && done;
  assign chk_cap = (state == RDATA);

  sort_order_checker #(
    .DATA_W(DATA_W)
  ) u_check (
    .clk (clk),
    .rst (rst),
    .clr (chk_clr),
    .cap (chk_cap),
    .data(mem_rdata),
    .err (order_err)
  );
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_initiator.sv
// tb_sort_initiator: directed + random jobs against a stub sorter memory,
// checked against a queue-based reference of the expected read-back.
module tb_sort_initiator;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 4;
`ifdef SORT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          done = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] mem_rdata = '0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          start_sort;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          order_err;

  sort_initiator #(
    .DATA_W(DW),
    .DEPTH (DP),
    .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .start_sort(start_sort),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  // stub sorter memory: synchronous read, sort-in-place or pattern overwrite
  logic [DW-1:0] mem [DP];
  logic [DW-1:0] pat [DP];
  logic          sort_req = 1'b0;
  logic          pat_req = 1'b0;

  always @(posedge clk) begin
    logic [DW-1:0] t;
    if (sort_req) begin
      for (int i = 0; i < DP; i++)
        for (int j = 0; j < DP - 1 - i; j++)
          if (mem[j] > mem[j+1]) begin
            t = mem[j];
            mem[j] = mem[j+1];
            mem[j+1] = t;
          end
    end else if (pat_req) begin
      for (int i = 0; i < DP; i++) mem[i] = pat[i];
    end else if (mem_we) begin
      mem[mem_addr] = mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // monitor: counts events and records every output handshake
  int            cyc = 0;
  int            we_cnt = 0;
  int            start_cnt = 0;
  int            hold_viol = 0;
  bit            hold_pend = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  logic          got_e[$];
  int            hs_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (mem_we) we_cnt++;
    if (start_sort) start_cnt++;
    if (hold_pend && (!out_valid || out_data !== hold_d || out_last !== hold_l))
      hold_viol++;
    hold_pend = out_valid && !out_ready;
    hold_d = out_data;
    hold_l = out_last;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      got_e.push_back(order_err);
      hs_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input string tag, input logic [DW-1:0] w[$]);
    for (int i = 0; i < w.size(); i++) begin
      in_valid = 1'b1;
      in_data = w[i];
      #1;
      if (i == 0 || i == w.size() - 1) begin
        chk($sformatf("%s_in_ready_%0d", tag, i), in_ready, 1);
        chk($sformatf("%s_we_%0d", tag, i), mem_we, 1);
        chk($sformatf("%s_addr_%0d", tag, i), mem_addr, i);
        chk($sformatf("%s_wdata_%0d", tag, i), mem_wdata, w[i]);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data = '0;
  endtask

  // stub sorter finishes some cycles after start; done is a one-cycle level
  task automatic sort_done(input string tag, input int dly, input bit use_pat);
    repeat (dly) step();
    if (use_pat) pat_req = 1'b1;
    else sort_req = 1'b1;
    step();
    pat_req = 1'b0;
    sort_req = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    step();
    chk({tag, "_lat2"}, out_valid, 0);
    step();
    chk({tag, "_lat3"}, out_valid, 1);
  endtask

  task automatic readout(input string tag, input int base, input int bp_idx);
    int budget;
    bit bp_done;
    budget = 400;
    bp_done = 1'b0;
    out_ready = 1'b1;
    while (busy && budget > 0) begin
      if (!bp_done && out_valid && (got_d.size() - base) == bp_idx) begin
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        bp_done = 1'b1;
      end else begin
        step();
      end
      budget--;
    end
    chk({tag, "_budget"}, (budget > 0), 1);
  endtask

  task automatic verify(input string tag, input logic [DW-1:0] exp[$],
                        input int base);
    bit e_err;
    e_err = 1'b0;
    chk({tag, "_count"}, got_d.size() - base, DP);
    for (int k = 0; k < DP; k++) begin
      if (base + k < got_d.size()) begin
        if (k > 0 && exp[k] < exp[k-1]) e_err = CHK;
        chk($sformatf("%s_data_%0d", tag, k), got_d[base+k], exp[k]);
        chk($sformatf("%s_last_%0d", tag, k), got_l[base+k], (k == DP - 1));
        chk($sformatf("%s_err_%0d", tag, k), got_e[base+k], e_err);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w[$];
    logic [DW-1:0] e[$];
    int base;
    int we0;
    int bad;

    // reset state
    rst = 1'b1;
    repeat (2) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_start", start_sort, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_order_err", order_err, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // reset in the middle of a load
    step();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      step();
    end
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_we", mem_we, 0);
    step();
    chk("mid_idle_busy", busy, 0);
    chk("mid_idle_we", mem_we, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    done = 1'b1;
    repeat (30) step();
    chk("mid_done_ignored", busy, 0);
    chk("mid_no_start", start_cnt, 0);
    done = 1'b0;
    step();

    // job 1: 15..0, sorted by the stub
    w.delete();
    for (int i = 0; i < DP; i++) w.push_back(8'(15 - i));
    e = w;
    e.sort();
    base = got_d.size();
    we0 = we_cnt;
    load("j1", w);
    chk("j1_start", start_sort, 1);
    step();
    chk("j1_start_once", start_sort, 0);
    chk("j1_writes", we_cnt - we0, DP);
    sort_done("j1", 18, 1'b0);
    readout("j1", base, -1);
    verify("j1", e, base);
    bad = 0;
    if (hs_cyc.size() >= base + DP) begin
      for (int k = 1; k < DP; k++)
        if (hs_cyc[base+k] - hs_cyc[base+k-1] != 3) bad++;
    end else begin
      bad = 99;
    end
    chk("j1_throughput", bad, 0);
    chk("j1_start_cnt", start_cnt, 1);

    // job 2: random words, input held valid while busy, backpressure on word 3
    w.delete();
    for (int i = 0; i < DP; i++) w.push_back(8'($urandom));
    e = w;
    e.sort();
    base = got_d.size();
    load("j2", w);
    chk("j2_start", start_sort, 1);
    in_valid = 1'b1;
    in_data = 8'($urandom);
    we0 = we_cnt;
    step();
    #1;
    chk("j2_wait_in_ready", in_ready, 0);
    chk("j2_wait_we", mem_we, 0);
    sort_done("j2", 17, 1'b0);
    #1;
    chk("j2_out_in_ready", in_ready, 0);
    chk("j2_out_we", mem_we, 0);
    in_valid = 1'b0;
    readout("j2", base, 3);
    chk("j2_no_writes", we_cnt - we0, 0);
    chk("j2_hold", hold_viol, 0);
    verify("j2", e, base);
    chk("j2_start_cnt", start_cnt, 2);

    // job 3: done already high when WAIT is entered
    w.delete();
    for (int i = 0; i < DP; i++) w.push_back(8'($urandom));
    w.sort();
    e = w;
    base = got_d.size();
    we0 = we_cnt;
    done = 1'b1;
    load("j3", w);
    chk("j3_writes", we_cnt - we0, DP);
    chk("j3_start", start_sort, 1);
    step();
    chk("j3_lat0", out_valid, 0);
    step();
    step();
    chk("j3_lat2", out_valid, 0);
    step();
    chk("j3_lat3", out_valid, 1);
    done = 1'b0;
    readout("j3", base, -1);
    verify("j3", e, base);
    chk("j3_start_cnt", start_cnt, 3);

    // job 4: stub returns a sequence with one descent
    e.delete();
    e.push_back(8'd1);
    e.push_back(8'd2);
    e.push_back(8'd5);
    e.push_back(8'd4);
    for (int i = 4; i < DP; i++) e.push_back(8'(i + 2));
    for (int i = 0; i < DP; i++) pat[i] = e[i];
    w.delete();
    for (int i = 0; i < DP; i++) w.push_back(8'($urandom));
    base = got_d.size();
    load("j4", w);
    chk("j4_start", start_sort, 1);
    sort_done("j4", 18, 1'b1);
    readout("j4", base, -1);
    verify("j4", e, base);
    chk("j4_sticky", order_err, CHK);

    // job 5: clean job after an error clears the flag
    w.delete();
    for (int i = 0; i < DP; i++) w.push_back(8'($urandom));
    e = w;
    e.sort();
    base = got_d.size();
    load("j5", w);
    chk("j5_start", start_sort, 1);
    chk("j5_err_kept", order_err, CHK);
    sort_done("j5", 18, 1'b0);
    readout("j5", base, -1);
    verify("j5", e, base);
    chk("j5_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
